ext_irq_arbiter: RTL and testbench
==================================

Name: ext_irq_arbiter

Overview:
- Platform-level external-interrupt arbiter that feeds the CPU's CSR unit. Collects NUM_SRC interrupt sources, latches rising edges as pending and picks the highest-priority enabled one.
- Drives meip_o into the CSR `interrupt` input.
- Software configures it and runs a claim/complete handshake through a simple single-cycle register port, so the core services exactly one source at a time.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..8); source bit k has ID k+1; ID 0 means "none".
- PRIO_W, 3, priority width per source; NUM_SRC*PRIO_W must be <= 32.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- src_i  input  NUM_SRC  raw interrupt lines, asynchronous to clk, rising-edge triggered
- reg_req  input  1  register access strobe, one access per cycle
- reg_we  input  1  1 = write, 0 = read
- reg_addr  input  5  byte offset: 0x00 PENDING (RO), 0x04 ENABLE (RW), 0x08 PRIORITY (RW, source k at [k*PRIO_W +: PRIO_W]), 0x0C THRESHOLD (RW, [PRIO_W-1:0]), 0x10 CLAIM (read) / COMPLETE (write)
- reg_wdata  input  32  write data
- reg_rdata  output  32  read data, valid when reg_ready=1
- reg_ready  output  1  response strobe, one cycle after reg_req
- meip_o  output  1  external interrupt request to CSR unit
- irq_id_o  output  4  currently selected best ID (0 = none), for debug/trace

Behaviour:
- Reset state:
  - All registers 0, state IDLE, synchronizers 0.
  - Outputs: meip_o=0, irq_id_o=0, reg_ready=0, reg_rdata=0.
- Source path:
  - 2-flop synchronizer per line, then an edge flop.
  - Edge = sync2 & ~sync_d.
  - Edge sets pending[k] regardless of ENABLE.
- Arbitration:
  - Candidates are sources with pending & enable & (prio > threshold).
  - Highest priority wins; equal priority resolves to the lowest ID.
  - Priority 0 never fires.
  - Winner is registered into best_id every cycle, so irq_id_o = best_id.
- meip_o = (best_id != 0) && state==IDLE, combinational from registers.
  - Latency: src_i rising before edge 1 -> pending set at edge 3 -> meip_o high after edge 4.
- FSM IDLE / CLAIMED, with claimed_id register:
  - IDLE, CLAIM read: reg_rdata = best_id.
    - If best_id != 0: clear pending[best_id-1], claimed_id <= best_id, go CLAIMED.
    - If best_id == 0: return 0, stay IDLE.
  - CLAIMED, CLAIM read: return 0, no state change.
  - CLAIMED, COMPLETE write with wdata[3:0]==claimed_id: go IDLE, claimed_id <= 0. Mismatched ID is ignored.
  - IDLE, COMPLETE write: ignored.
- Register port:
  - Access is captured on a reg_req cycle.
  - reg_ready pulses exactly 1 cycle later, with reg_rdata valid in that cycle.
  - reg_rdata = 0 on write responses, on no-response cycles and on unmapped offsets.
  - Writes to unmapped offsets and to PENDING are ignored.
  - ENABLE and PRIORITY writes mask off unused upper bits; reads return them as 0.
- Simultaneous events:
  - Edge and claim-clear on the same source in the same cycle: set wins, so the source stays pending.
  - Config writes take effect on best_id one cycle after the write edge.
  - A new edge on the claimed source during CLAIMED re-pends it; it is re-arbitrated after COMPLETE.
- Reset mid-operation:
  - rstn low clears pending, the claim and meip_o immediately (async).
  - An outstanding reg response is dropped.

Test Plan:
1. Reset, ENABLE=0xF, PRIORITY=all 1, THRESHOLD=0, pulse src_i[2] -> meip_o high 4 cycles after the edge, irq_id_o=3; CLAIM read returns 3, meip_o drops the next cycle; COMPLETE write 3 -> IDLE, meip_o stays 0.
2. src 1 prio 2, src 3 prio 5, src 4 prio 5, all pending together -> CLAIM returns 3; after COMPLETE 3 CLAIM returns 4; then 1; then 0.
3. THRESHOLD=5 with the src 3 prio 5 pending -> meip_o stays 0; THRESHOLD=4 -> meip_o high the cycle after the write; ENABLE bit cleared -> meip_o low, PENDING still shows the bit.
4. In CLAIMED with ID 2: COMPLETE write 1 -> still CLAIMED, meip_o=0; CLAIM read returns 0; COMPLETE write 2 -> IDLE.
5. Rising edge on src 2 in the same cycle its claim clears pending -> PENDING bit 1 stays set; after COMPLETE, meip_o reasserts with ID 2.
6. rstn pulsed low while CLAIMED with pending bits set -> all outputs 0 asynchronously, PENDING reads 0 after release, sources held high give no new edge.

Source files
------------

// File: rtl/ext_irq_arbiter.sv
// External interrupt arbiter: edge-latched sources, priority select,
// claim/complete handshake over a single-cycle register port.
module ext_irq_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               reg_req,
  input  logic               reg_we,
  input  logic [4:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               reg_ready,
  output logic               meip_o,
  output logic [3:0]         irq_id_o
);

  localparam int PW = NUM_SRC * PRIO_W;

  typedef enum logic {
    IDLE,
    CLAIMED
  } state_e;

  state_e state_q, state_d;

  logic [NUM_SRC-1:0] sync1_q, sync2_q, syncd_q;
  logic [1:0]         arm_q, arm_d;
  logic [NUM_SRC-1:0] edge_v;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] en_q, en_d;
  logic [PW-1:0]      prio_q, prio_d;
  logic [PRIO_W-1:0]  thr_q, thr_d;
  logic [3:0]         best_q, best_d;
  logic [3:0]         claim_q, claim_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ready_q;
  logic [PRIO_W-1:0]  win_pr;
  logic               unused_wdata;

  assign unused_wdata = ^reg_wdata;

  // Edges stay masked until the sync chain holds real samples,
  // so lines already high at reset release do not fire.
  assign arm_d  = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
  assign edge_v = sync2_q & ~syncd_q & {NUM_SRC{arm_q == 2'd3}};

  always_comb begin
    best_d = '0;
    win_pr = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (pend_q[k] && en_q[k] &&
          prio_q[k*PRIO_W +: PRIO_W] > thr_q &&
          prio_q[k*PRIO_W +: PRIO_W] > win_pr) begin
        win_pr = prio_q[k*PRIO_W +: PRIO_W];
        best_d = 4'(k + 1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    claim_d = claim_q;
    clr     = '0;
    rdata_d = '0;
    en_d    = en_q;
    prio_d  = prio_q;
    thr_d   = thr_q;
    if (reg_req) begin
      unique case (1'b1)
        reg_addr == 5'h00: begin
          if (!reg_we) rdata_d = 32'(pend_q);
        end
        reg_addr == 5'h04: begin
          if (reg_we) en_d = reg_wdata[NUM_SRC-1:0];
          else rdata_d = 32'(en_q);
        end
        reg_addr == 5'h08: begin
          if (reg_we) prio_d = reg_wdata[PW-1:0];
          else rdata_d = 32'(prio_q);
        end
        reg_addr == 5'h0C: begin
          if (reg_we) thr_d = reg_wdata[PRIO_W-1:0];
          else rdata_d = 32'(thr_q);
        end
        reg_addr == 5'h10: begin
          if (reg_we) begin
            if (state_q == CLAIMED && reg_wdata[3:0] == claim_q) begin
              state_d = IDLE;
              claim_d = '0;
            end
          end else if (state_q == IDLE && best_q != '0) begin
            rdata_d = 32'(best_q);
            state_d = CLAIMED;
            claim_d = best_q;
            for (int k = 0; k < NUM_SRC; k++)
              clr[k] = (best_q == 4'(k + 1));
          end
        end
        default: ;
      endcase
    end
  end

  // A same-cycle edge wins over the claim clear.
  assign pend_d = (pend_q & ~clr) | edge_v;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      syncd_q <= '0;
      arm_q   <= '0;
      pend_q  <= '0;
      en_q    <= '0;
      prio_q  <= '0;
      thr_q   <= '0;
      best_q  <= '0;
      claim_q <= '0;
      state_q <= IDLE;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      sync1_q <= src_i;
      sync2_q <= sync1_q;
      syncd_q <= sync2_q;
      arm_q   <= arm_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
      prio_q  <= prio_d;
      thr_q   <= thr_d;
      best_q  <= best_d;
      claim_q <= claim_d;
      state_q <= state_d;
      rdata_q <= rdata_d;
      ready_q <= reg_req;
    end
  end

  assign reg_rdata = rdata_q;
  assign reg_ready = ready_q;
  assign meip_o    = (best_q != '0) && (state_q == IDLE);
  assign irq_id_o  = best_q;

endmodule

// File: tb/tb_ext_irq_arbiter.sv
// Scenario bench for ext_irq_arbiter; register responses are
// checked against a queue of expected read data.
module tb_ext_irq_arbiter;

  localparam logic [4:0] A_PEND = 5'h00;
  localparam logic [4:0] A_EN   = 5'h04;
  localparam logic [4:0] A_PRIO = 5'h08;
  localparam logic [4:0] A_THR  = 5'h0C;
  localparam logic [4:0] A_CLM  = 5'h10;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  src_i;
  logic        reg_req;
  logic        reg_we;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_ready;
  logic        meip_o;
  logic [3:0]  irq_id_o;

  int npass = 0;
  int ntot  = 0;
  logic [31:0] sbq[$];

  ext_irq_arbiter #(.NUM_SRC(4), .PRIO_W(3)) dut (
    .clk(clk), .rstn(rstn), .src_i(src_i),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ready(reg_ready),
    .meip_o(meip_o), .irq_id_o(irq_id_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn && reg_ready) begin
      logic [31:0] e;
      ntot++;
      if (sbq.size() == 0) begin
        $display("FAIL rsp_unexpected rdata=%h exp none", reg_rdata);
      end else begin
        e = sbq.pop_front();
        if (reg_rdata !== e)
          $display("FAIL rsp_data got %h exp %h", reg_rdata, e);
        else npass++;
      end
    end
  end

  task automatic rd(input logic [4:0] a, input logic [31:0] e);
    @(negedge clk);
    reg_req = 1'b1; reg_we = 1'b0; reg_addr = a; reg_wdata = '0;
    sbq.push_back(e);
    @(negedge clk);
    reg_req = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    sbq.push_back(32'h0);
    @(negedge clk);
    reg_req = 1'b0; reg_we = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] m);
    @(negedge clk);
    src_i = src_i | m;
    repeat (2) @(negedge clk);
    src_i = src_i & ~m;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; src_i = '0; reg_req = 1'b0; reg_we = 1'b0;
    reg_addr = '0; reg_wdata = '0;
    repeat (3) @(negedge clk);
    ntot++; if (meip_o !== 1'b0) $display("FAIL rst_meip got %0b exp 0", meip_o); else npass++;
    ntot++; if (irq_id_o !== 4'd0) $display("FAIL rst_id got %0d exp 0", irq_id_o); else npass++;
    ntot++; if (reg_ready !== 1'b0) $display("FAIL rst_ready got %0b exp 0", reg_ready); else npass++;
    ntot++; if (reg_rdata !== 32'h0) $display("FAIL rst_rdata got %h exp 0", reg_rdata); else npass++;
    rstn = 1'b1;
    rd(A_PEND, 32'h0);
    rd(A_EN, 32'h0);
    rd(A_PRIO, 32'h0);
    rd(A_THR, 32'h0);
    rd(A_CLM, 32'h0);
  endtask

  task automatic test_regs();
    wr(A_EN, 32'hFFFF_FFFF);   rd(A_EN, 32'hF);
    wr(A_PRIO, 32'hFFFF_FFFF); rd(A_PRIO, 32'hFFF);
    wr(A_THR, 32'hFFFF_FFFF);  rd(A_THR, 32'h7);
    wr(5'h14, 32'h1234_5678);  rd(5'h14, 32'h0);
    wr(A_PEND, 32'hF);         rd(A_PEND, 32'h0);
    rd(5'h02, 32'h0);
  endtask

  task automatic test_basic();
    wr(A_EN, 32'hF);
    wr(A_PRIO, 32'h249);
    wr(A_THR, 32'h0);
    @(negedge clk);
    src_i[2] = 1'b1;
    repeat (3) @(negedge clk);
    ntot++; if (meip_o !== 1'b0) $display("FAIL lat_early got %0b exp 0", meip_o); else npass++;
    @(negedge clk);
    ntot++; if (meip_o !== 1'b1) $display("FAIL lat_meip got %0b exp 1", meip_o); else npass++;
    ntot++; if (irq_id_o !== 4'd3) $display("FAIL lat_id got %0d exp 3", irq_id_o); else npass++;
    src_i[2] = 1'b0;
    rd(A_CLM, 32'd3);
    ntot++; if (meip_o !== 1'b0) $display("FAIL claim_drop got %0b exp 0", meip_o); else npass++;
    wr(A_CLM, 32'd3);
    repeat (2) @(negedge clk);
    ntot++; if (meip_o !== 1'b0) $display("FAIL cmpl_meip got %0b exp 0", meip_o); else npass++;
    ntot++; if (irq_id_o !== 4'd0) $display("FAIL cmpl_id got %0d exp 0", irq_id_o); else npass++;
  endtask

  task automatic test_priority();
    wr(A_PRIO, 32'hB4A);
    pulse(4'b1101);
    rd(A_PEND, 32'hD);
    rd(A_CLM, 32'd3); wr(A_CLM, 32'd3);
    rd(A_CLM, 32'd4); wr(A_CLM, 32'd4);
    rd(A_CLM, 32'd1); wr(A_CLM, 32'd1);
    rd(A_CLM, 32'd0);
  endtask

  task automatic test_threshold();
    wr(A_THR, 32'd5);
    pulse(4'b0100);
    ntot++; if (meip_o !== 1'b0) $display("FAIL thr5_meip got %0b exp 0", meip_o); else npass++;
    wr(A_THR, 32'd4);
    ntot++; if (meip_o !== 1'b0) $display("FAIL thr4_early got %0b exp 0", meip_o); else npass++;
    @(negedge clk);
    ntot++; if (meip_o !== 1'b1) $display("FAIL thr4_meip got %0b exp 1", meip_o); else npass++;
    ntot++; if (irq_id_o !== 4'd3) $display("FAIL thr4_id got %0d exp 3", irq_id_o); else npass++;
    wr(A_EN, 32'hB);
    @(negedge clk);
    ntot++; if (meip_o !== 1'b0) $display("FAIL en_off_meip got %0b exp 0", meip_o); else npass++;
    rd(A_PEND, 32'h4);
    wr(A_EN, 32'hF);
    @(negedge clk);
    rd(A_CLM, 32'd3); wr(A_CLM, 32'd3);
    wr(A_THR, 32'd0);
  endtask

  task automatic test_mismatch();
    pulse(4'b0010);
    rd(A_CLM, 32'd2);
    pulse(4'b0001);
    ntot++; if (meip_o !== 1'b0) $display("FAIL clm_meip got %0b exp 0", meip_o); else npass++;
    ntot++; if (irq_id_o !== 4'd1) $display("FAIL clm_id got %0d exp 1", irq_id_o); else npass++;
    wr(A_CLM, 32'd1);
    ntot++; if (meip_o !== 1'b0) $display("FAIL bad_cmpl got %0b exp 0", meip_o); else npass++;
    rd(A_CLM, 32'd0);
    wr(A_CLM, 32'd2);
    ntot++; if (meip_o !== 1'b1) $display("FAIL good_cmpl got %0b exp 1", meip_o); else npass++;
    rd(A_CLM, 32'd1); wr(A_CLM, 32'd1);
  endtask

  task automatic test_collision();
    pulse(4'b0010);
    ntot++; if (irq_id_o !== 4'd2) $display("FAIL col_id0 got %0d exp 2", irq_id_o); else npass++;
    @(negedge clk);
    src_i[1] = 1'b1;
    @(negedge clk);
    rd(A_CLM, 32'd2);
    rd(A_PEND, 32'h2);
    wr(A_CLM, 32'd2);
    ntot++; if (meip_o !== 1'b1) $display("FAIL col_meip got %0b exp 1", meip_o); else npass++;
    ntot++; if (irq_id_o !== 4'd2) $display("FAIL col_id got %0d exp 2", irq_id_o); else npass++;
    rd(A_CLM, 32'd2);
    src_i[1] = 1'b0;
    wr(A_CLM, 32'd2);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    src_i = 4'b1001;
    repeat (5) @(negedge clk);
    ntot++; if (irq_id_o !== 4'd4) $display("FAIL ar_id got %0d exp 4", irq_id_o); else npass++;
    rd(A_CLM, 32'd4);
    @(negedge clk);
    reg_req = 1'b1; reg_we = 1'b0; reg_addr = A_PEND;
    @(posedge clk);
    #2;
    rstn = 1'b0; reg_req = 1'b0;
    #1;
    ntot++; if (reg_ready !== 1'b0) $display("FAIL ar_ready got %0b exp 0", reg_ready); else npass++;
    ntot++; if (reg_rdata !== 32'h0) $display("FAIL ar_rdata got %h exp 0", reg_rdata); else npass++;
    ntot++; if (irq_id_o !== 4'd0) $display("FAIL ar_idz got %0d exp 0", irq_id_o); else npass++;
    ntot++; if (meip_o !== 1'b0) $display("FAIL ar_meip got %0b exp 0", meip_o); else npass++;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    rd(A_PEND, 32'h0);
    wr(A_EN, 32'hF);
    wr(A_PRIO, 32'h249);
    repeat (3) @(negedge clk);
    ntot++; if (meip_o !== 1'b0) $display("FAIL ar_hold_meip got %0b exp 0", meip_o); else npass++;
    rd(A_PEND, 32'h0);
    src_i = '0;
    repeat (4) @(negedge clk);
    pulse(4'b0001);
    ntot++; if (irq_id_o !== 4'd1) $display("FAIL ar_new_id got %0d exp 1", irq_id_o); else npass++;
    rd(A_CLM, 32'd1); wr(A_CLM, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_regs();
    test_basic();
    test_priority();
    test_threshold();
    test_mismatch();
    test_collision();
    test_async_reset();
    repeat (3) @(negedge clk);
    ntot++;
    if (sbq.size() != 0) $display("FAIL sb_drain got %0d exp 0", sbq.size());
    else npass++;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
